// File: rtl/axi4l_decoder_if.sv
// AXI4-Lite bus bundle for the 1:N decoder: master-facing s_* and per-slave m_* channels.
// The slave modport is the decoder's view; the master modport is the opposite side.
interface axi4l_decoder_if #(
  parameter int unsigned N_SLAVES = 2
);
  logic                      s_awvalid, s_awready;
  logic [31:0]               s_awaddr;
  logic                      s_wvalid, s_wready;
  logic [31:0]               s_wdata;
  logic [3:0]                s_wstrb;
  logic                      s_bvalid, s_bready;
  logic [1:0]                s_bresp;
  logic                      s_arvalid, s_arready;
  logic [31:0]               s_araddr;
  logic                      s_rvalid, s_rready;
  logic [31:0]               s_rdata;
  logic [1:0]                s_rresp;

  logic [N_SLAVES-1:0]       m_awvalid, m_awready;
  logic [31:0]               m_awaddr;
  logic [N_SLAVES-1:0]       m_wvalid, m_wready;
  logic [31:0]               m_wdata;
  logic [3:0]                m_wstrb;
  logic [N_SLAVES-1:0]       m_bvalid, m_bready;
  logic [N_SLAVES-1:0][1:0]  m_bresp;
  logic [N_SLAVES-1:0]       m_arvalid, m_arready;
  logic [31:0]               m_araddr;
  logic [N_SLAVES-1:0]       m_rvalid, m_rready;
  logic [N_SLAVES-1:0][31:0] m_rdata;
  logic [N_SLAVES-1:0][1:0]  m_rresp;

  modport slave (
    input  s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
           s_arvalid, s_araddr, s_rready,
    output s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata, s_rresp,
    output m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
           m_arvalid, m_araddr, m_rready,
    input  m_awready, m_wready, m_bvalid, m_bresp, m_arready, m_rvalid, m_rdata, m_rresp
  );

  modport master (
    output s_awvalid, s_awaddr, s_wvalid, s_wdata, s_wstrb, s_bready,
           s_arvalid, s_araddr, s_rready,
    input  s_awready, s_wready, s_bvalid, s_bresp, s_arready, s_rvalid, s_rdata, s_rresp,
    input  m_awvalid, m_awaddr, m_wvalid, m_wdata, m_wstrb, m_bready,
           m_arvalid, m_araddr, m_rready,
    output m_awready, m_wready, m_bvalid, m_bresp, m_arready, m_rvalid, m_rdata, m_rresp
  );
endinterface

// File: rtl/axi4l_decoder.sv
// 1-master to N-slave AXI4-Lite address decoder with independent single-outstanding
// write and read paths; unmapped addresses are answered locally with DECERR.
module axi4l_decoder #(
  parameter int unsigned                  N_SLAVES   = 2,
  parameter logic [N_SLAVES-1:0][31:0]    SLAVE_BASE = {32'h4000_1000, 32'h4000_0000},
  parameter logic [N_SLAVES-1:0][31:0]    SLAVE_MASK = {32'hFFFF_F000, 32'hFFFF_F000}
) (
  input  logic                  clk,
  input  logic                  rst,
  axi4l_decoder_if.slave        bus
);
  localparam int unsigned SW     = (N_SLAVES > 1) ? $clog2(N_SLAVES) : 1;
  localparam logic [1:0]  OKAY   = 2'b00;
  localparam logic [1:0]  DECERR = 2'b11;

  typedef enum logic [1:0] {W_IDLE, W_FWD, W_ERR, W_RESP} w_state_t;
  typedef enum logic [1:0] {R_IDLE, R_FWD, R_ERR, R_RESP} r_state_t;

  w_state_t        w_state, w_next;
  r_state_t        r_state, r_next;
  logic [SW-1:0]   w_sel, r_sel;
  logic            aw_done, w_done, aw_fin, w_fin;
  logic [SW:0]     aw_dec, ar_dec;

  // MSB = hit flag, low bits = index of the lowest matching window.
  function automatic logic [SW:0] decode(input logic [31:0] addr);
    decode = '0;
    for (int unsigned i = 0; i < N_SLAVES; i++) begin
      if (!decode[SW] && ((addr & SLAVE_MASK[i]) == SLAVE_BASE[i]))
        decode = {1'b1, SW'(i)};
    end
  endfunction

  assign aw_dec      = decode(bus.s_awaddr);
  assign ar_dec      = decode(bus.s_araddr);
  assign bus.m_wdata = bus.s_wdata;
  assign bus.m_wstrb = bus.s_wstrb;

  always_ff @(posedge clk) begin
    if (rst) begin
      w_state <= W_IDLE;
      w_sel   <= '0;
      aw_done <= 1'b0;
      w_done  <= 1'b0;
    end else begin
      w_state <= w_next;
      if (w_state == W_IDLE && bus.s_awvalid) begin
        w_sel   <= aw_dec[SW-1:0];
        aw_done <= 1'b0;
        w_done  <= 1'b0;
      end else begin
        aw_done <= aw_fin;
        w_done  <= w_fin;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_state == W_IDLE && bus.s_awvalid) bus.m_awaddr <= bus.s_awaddr;
    if (r_state == R_IDLE && bus.s_arvalid) bus.m_araddr <= bus.s_araddr;
  end

  always_comb begin
    w_next         = w_state;
    aw_fin         = aw_done;
    w_fin          = w_done;
    bus.s_awready  = 1'b0;
    bus.s_wready   = 1'b0;
    bus.s_bvalid   = 1'b0;
    bus.s_bresp    = OKAY;
    bus.m_awvalid  = '0;
    bus.m_wvalid   = '0;
    bus.m_bready   = '0;
    unique case (w_state)
      W_IDLE: begin
        bus.s_awready = 1'b1;
        if (bus.s_awvalid) w_next = aw_dec[SW] ? W_FWD : W_ERR;
      end
      W_FWD: begin
        bus.m_awvalid[w_sel] = !aw_done;
        bus.m_wvalid[w_sel]  = bus.s_wvalid && !w_done;
        bus.s_wready         = bus.m_wready[w_sel] && !w_done;
        aw_fin = aw_done || bus.m_awready[w_sel];
        w_fin  = w_done || (bus.s_wvalid && bus.m_wready[w_sel]);
        if (aw_fin && w_fin) w_next = W_RESP;
      end
      W_ERR: begin
        // w_done doubles as "error beat swallowed": B is only offered after it.
        bus.s_wready = !w_done;
        w_fin        = w_done || bus.s_wvalid;
        bus.s_bvalid = w_done;
        bus.s_bresp  = w_done ? DECERR : OKAY;
        if (w_done && bus.s_bready) w_next = W_IDLE;
      end
      W_RESP: begin
        bus.s_bvalid        = bus.m_bvalid[w_sel];
        bus.s_bresp         = bus.m_bresp[w_sel];
        bus.m_bready[w_sel] = bus.s_bready;
        if (bus.m_bvalid[w_sel] && bus.s_bready) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= R_IDLE;
      r_sel   <= '0;
    end else begin
      r_state <= r_next;
      if (r_state == R_IDLE && bus.s_arvalid) r_sel <= ar_dec[SW-1:0];
    end
  end

  always_comb begin
    r_next        = r_state;
    bus.s_arready = 1'b0;
    bus.s_rvalid  = 1'b0;
    bus.s_rdata   = '0;
    bus.s_rresp   = OKAY;
    bus.m_arvalid = '0;
    bus.m_rready  = '0;
    unique case (r_state)
      R_IDLE: begin
        bus.s_arready = 1'b1;
        if (bus.s_arvalid) r_next = ar_dec[SW] ? R_FWD : R_ERR;
      end
      R_FWD: begin
        bus.m_arvalid[r_sel] = 1'b1;
        if (bus.m_arready[r_sel]) r_next = R_RESP;
      end
      R_ERR: begin
        bus.s_rvalid = 1'b1;
        bus.s_rresp  = DECERR;
        if (bus.s_rready) r_next = R_IDLE;
      end
      R_RESP: begin
        bus.s_rvalid        = bus.m_rvalid[r_sel];
        bus.s_rdata         = bus.m_rdata[r_sel];
        bus.s_rresp         = bus.m_rresp[r_sel];
        bus.m_rready[r_sel] = bus.s_rready;
        if (bus.m_rvalid[r_sel] && bus.s_rready) r_next = R_IDLE;
      end
      default: r_next = R_IDLE;
    endcase
  end
endmodule

// File: tb/tb_axi4l_decoder.sv
// Directed bench for axi4l_decoder: expected B/R responses are queued at issue time and
// popped by an independent monitor on each master-side response handshake.
module tb_axi4l_decoder;
  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_fail   = 0;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
  } r_exp_t;

  logic [1:0] exp_b[$];
  r_exp_t     exp_r[$];
  logic [1:0] eb;
  r_exp_t     er;

  always #5 clk = ~clk;

  axi4l_decoder_if #(.N_SLAVES(2)) bus ();

  axi4l_decoder #(.N_SLAVES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, required %0h", name, act, exp);
    end
  endtask

  // Scoreboard monitor: compares every master-side B/R handshake with the queue head.
  always @(negedge clk) begin
    if (!rst) begin
      if (bus.s_bvalid && bus.s_bready) begin
        n_checks++;
        if (exp_b.size() == 0) begin
          n_fail++;
          $display("FAIL b_unexpected: got bresp %b, required no response", bus.s_bresp);
        end else begin
          eb = exp_b.pop_front();
          if (bus.s_bresp !== eb) begin
            n_fail++;
            $display("FAIL b_resp: got %b, required %b", bus.s_bresp, eb);
          end
        end
      end
      if (bus.s_rvalid && bus.s_rready) begin
        n_checks++;
        if (exp_r.size() == 0) begin
          n_fail++;
          $display("FAIL r_unexpected: got rdata %h rresp %b, required no response",
                   bus.s_rdata, bus.s_rresp);
        end else begin
          er = exp_r.pop_front();
          if (bus.s_rdata !== er.data || bus.s_rresp !== er.resp) begin
            n_fail++;
            $display("FAIL r_resp: got %h/%b, required %h/%b",
                     bus.s_rdata, bus.s_rresp, er.data, er.resp);
          end
        end
      end
    end
  end

  initial begin
    rst = 1'b1;
    bus.s_awvalid = 1'b0; bus.s_awaddr = '0; bus.s_wvalid = 1'b0; bus.s_wdata = '0;
    bus.s_wstrb = '0; bus.s_bready = 1'b0; bus.s_arvalid = 1'b0; bus.s_araddr = '0;
    bus.s_rready = 1'b0;
    bus.m_awready = '0; bus.m_wready = '0; bus.m_bvalid = '0; bus.m_bresp = '0;
    bus.m_arready = '0; bus.m_rvalid = '0; bus.m_rdata = '0; bus.m_rresp = '0;
    bus.m_bresp[1] = 2'b01;
    bus.m_rdata[0] = 32'h1111_1111;

    // Reset state
    tick();
    mid();
    chk("rst_awready", bus.s_awready, 1);
    chk("rst_arready", bus.s_arready, 1);
    chk("rst_wready", bus.s_wready, 0);
    chk("rst_bvalid", bus.s_bvalid, 0);
    chk("rst_rvalid", bus.s_rvalid, 0);
    chk("rst_rdata", bus.s_rdata, 0);
    chk("rst_m_valids", {bus.m_awvalid, bus.m_wvalid, bus.m_arvalid}, 0);
    chk("rst_m_readys", {bus.m_bready, bus.m_rready}, 0);
    tick();
    rst = 1'b0;

    // Write to slave 0
    tick();
    bus.s_awvalid = 1'b1; bus.s_awaddr = 32'h4000_0004;
    bus.s_wvalid = 1'b1; bus.s_wdata = 32'h0000_00FF; bus.s_wstrb = 4'hF;
    exp_b.push_back(2'b00);
    mid();
    chk("w1_wready_idle", bus.s_wready, 0);
    tick();
    bus.s_awvalid = 1'b0;
    mid();
    chk("w1_m_awvalid", bus.m_awvalid, 2'b01);
    chk("w1_m_awaddr", bus.m_awaddr, 32'h4000_0004);
    chk("w1_m_wdata", bus.m_wdata, 32'h0000_00FF);
    chk("w1_m_wstrb", bus.m_wstrb, 4'hF);
    chk("w1_m_wvalid", bus.m_wvalid, 2'b01);
    chk("w1_wready_noslave", bus.s_wready, 0);
    tick();
    bus.m_awready = 2'b01; bus.m_wready = 2'b01;
    mid();
    chk("w1_wready_slave", bus.s_wready, 1);
    chk("w1_awready_busy", bus.s_awready, 0);
    tick();
    bus.m_awready = '0; bus.m_wready = '0; bus.s_wvalid = 1'b0;
    bus.m_bvalid = 2'b01; bus.s_bready = 1'b1;
    mid();
    chk("w1_bvalid", bus.s_bvalid, 1);
    chk("w1_m_bready", bus.m_bready, 2'b01);
    chk("w1_m_awvalid_resp", bus.m_awvalid, 2'b00);
    tick();
    bus.m_bvalid = '0; bus.s_bready = 1'b0;
    mid();
    chk("w1_back_idle", bus.s_awready, 1);

    // Read from slave 1
    tick();
    bus.s_arvalid = 1'b1; bus.s_araddr = 32'h4000_1000;
    exp_r.push_back('{data: 32'hDEAD_BEEF, resp: 2'b00});
    tick();
    bus.s_arvalid = 1'b0;
    mid();
    chk("r1_m_arvalid", bus.m_arvalid, 2'b10);
    chk("r1_m_araddr", bus.m_araddr, 32'h4000_1000);
    tick();
    bus.m_arready = 2'b10;
    tick();
    bus.m_arready = '0; bus.s_rready = 1'b1;
    mid();
    chk("r1_rvalid_wait", bus.s_rvalid, 0);
    chk("r1_m_arvalid_done", bus.m_arvalid, 2'b00);
    tick();
    bus.m_rvalid = 2'b10; bus.m_rdata[1] = 32'hDEAD_BEEF;
    mid();
    chk("r1_rvalid_same_cycle", bus.s_rvalid, 1);
    chk("r1_m_rready", bus.m_rready, 2'b10);
    tick();
    bus.m_rvalid = '0; bus.s_rready = 1'b0;

    // Unmapped write and read
    tick();
    bus.s_awvalid = 1'b1; bus.s_awaddr = 32'h5000_0000;
    bus.s_wvalid = 1'b1; bus.s_wdata = 32'h0000_0123;
    exp_b.push_back(2'b11);
    tick();
    bus.s_awvalid = 1'b0;
    mid();
    chk("werr_no_m_valid", {bus.m_awvalid, bus.m_wvalid}, 0);
    chk("werr_wready", bus.s_wready, 1);
    chk("werr_bvalid_early", bus.s_bvalid, 0);
    tick();
    bus.s_wvalid = 1'b0; bus.s_bready = 1'b1;
    mid();
    chk("werr_bvalid", bus.s_bvalid, 1);
    chk("werr_wready_done", bus.s_wready, 0);
    tick();
    bus.s_bready = 1'b0;
    bus.s_arvalid = 1'b1; bus.s_araddr = 32'h5000_0000;
    exp_r.push_back('{data: 32'h0, resp: 2'b11});
    tick();
    bus.s_arvalid = 1'b0; bus.s_rready = 1'b1;
    mid();
    chk("rerr_no_m_arvalid", bus.m_arvalid, 0);
    tick();
    bus.s_rready = 1'b0;

    // W valid three cycles ahead of AW
    tick();
    bus.s_wvalid = 1'b1; bus.s_wdata = 32'h0000_00AA; bus.m_wready = 2'b01;
    for (int i = 0; i < 3; i++) begin
      mid();
      chk("early_w_held", bus.s_wready, 0);
      tick();
    end
    bus.s_awvalid = 1'b1; bus.s_awaddr = 32'h4000_0008;
    exp_b.push_back(2'b00);
    mid();
    chk("early_w_held_aw", bus.s_wready, 0);
    tick();
    bus.s_awvalid = 1'b0; bus.m_awready = 2'b01;
    mid();
    chk("early_w_accept", bus.s_wready, 1);
    tick();
    bus.s_wvalid = 1'b0; bus.m_awready = '0; bus.m_wready = '0;
    bus.m_bvalid = 2'b01; bus.s_bready = 1'b1;
    mid();
    chk("early_w_bvalid", bus.s_bvalid, 1);
    tick();
    bus.m_bvalid = '0; bus.s_bready = 1'b0;
    mid();
    chk("early_w_once", {bus.s_bvalid, bus.m_awvalid, bus.m_wvalid}, 0);

    // AW and W together with ready slaves, then B back-pressure
    tick();
    bus.m_awready = 2'b01; bus.m_wready = 2'b01;
    bus.s_awvalid = 1'b1; bus.s_awaddr = 32'h4000_000C;
    bus.s_wvalid = 1'b1; bus.s_wdata = 32'h0000_5555;
    exp_b.push_back(2'b10);
    tick();
    bus.s_awvalid = 1'b0;
    mid();
    chk("same_m_awvalid", bus.m_awvalid, 2'b01);
    chk("same_wready", bus.s_wready, 1);
    tick();
    bus.s_wvalid = 1'b0; bus.m_awready = '0; bus.m_wready = '0;
    bus.m_bvalid = 2'b01; bus.m_bresp[0] = 2'b10; bus.s_bready = 1'b0;
    bus.s_awvalid = 1'b1; bus.s_awaddr = 32'h4000_0100;
    for (int i = 0; i < 5; i++) begin
      mid();
      chk("bp_bvalid", bus.s_bvalid, 1);
      chk("bp_bresp", bus.s_bresp, 2'b10);
      chk("bp_m_bready", bus.m_bready, 2'b00);
      chk("bp_awready", bus.s_awready, 0);
      chk("bp_no_new_aw", bus.m_awvalid, 2'b00);
      tick();
    end
    bus.s_bready = 1'b1; bus.s_awvalid = 1'b0;
    mid();
    chk("bp_m_bready_release", bus.m_bready, 2'b01);
    tick();
    bus.m_bvalid = '0; bus.s_bready = 1'b0; bus.m_bresp[0] = 2'b00;
    mid();
    chk("bp_awready_after", bus.s_awready, 1);
    chk("bp_awaddr_kept", bus.m_awaddr, 32'h4000_000C);

    // Reset in the middle of concurrent write and read forwarding
    tick();
    bus.s_awvalid = 1'b1; bus.s_awaddr = 32'h4000_0010; bus.s_wvalid = 1'b1;
    bus.s_arvalid = 1'b1; bus.s_araddr = 32'h4000_1004;
    tick();
    bus.s_awvalid = 1'b0; bus.s_arvalid = 1'b0;
    mid();
    chk("mid_m_awvalid", bus.m_awvalid, 2'b01);
    chk("mid_m_arvalid", bus.m_arvalid, 2'b10);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0; bus.s_wvalid = 1'b0;
    mid();
    chk("abort_m_valids", {bus.m_awvalid, bus.m_wvalid, bus.m_arvalid}, 0);
    chk("abort_awready", bus.s_awready, 1);
    chk("abort_arready", bus.s_arready, 1);
    chk("abort_bvalid", bus.s_bvalid, 0);
    chk("abort_rvalid", bus.s_rvalid, 0);

    tick();
    mid();
    chk("b_all_seen", exp_b.size(), 0);
    chk("r_all_seen", exp_r.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
